// File: rtl/uart_tx_fifo.sv
// UART transmitter (8N1, 16x tick prescaler) fed by a circular byte FIFO.
// Frames run back-to-back while the FIFO holds data; the serial line is registered.
module uart_tx_fifo #(
   parameter int DEPTH = 8
) (
   input  logic                       sys_clk_i,
   input  logic                       sys_rst_n_i,
   input  logic [15:0]                divisor_i,
   input  logic [7:0]                 data_i,
   input  logic                       valid_i,
   output logic                       ready_o,
   output logic [$clog2(DEPTH):0]     level_o,
   output logic                       busy_o,
   output logic                       overflow_o,
   output logic                       uart_tx_o
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } state_t;

   state_t        state_r;
   state_t        state_n_s;
   logic [7:0]    mem_r [DEPTH];
   logic [AW-1:0] wr_ptr_r;
   logic [AW-1:0] rd_ptr_r;
   logic [AW:0]   level_r;
   logic          overflow_r;
   logic [7:0]    shift_r;
   logic [7:0]    shift_n_s;
   logic [2:0]    bit_cnt_r;
   logic [2:0]    bit_cnt_n_s;
   logic [15:0]   presc_r;
   logic [15:0]   lim_s;
   logic [3:0]    tick_cnt_r;
   logic          tx_r;
   logic          tx_n_s;
   logic          push_s;
   logic          pop_s;
   logic          full_s;
   logic          tick_s;
   logic          bit_done_s;

   assign full_s     = (level_r == FULL_LVL);
   assign push_s     = valid_i && !full_s;
   assign lim_s      = (divisor_i == 16'd0) ? 16'd1 : divisor_i;
   // >= keeps a shrinking divisor from running the prescaler past its compare
   assign tick_s     = (presc_r >= (lim_s - 16'd1));
   assign bit_done_s = tick_s && (tick_cnt_r == 4'd15);

   assign ready_o    = !full_s;
   assign level_o    = level_r;
   assign busy_o     = (state_r != IDLE) || (level_r != '0);
   assign overflow_o = overflow_r;
   assign uart_tx_o  = tx_r;

   // FIFO storage write port
   always_ff @(posedge sys_clk_i) begin
      if (push_s) begin
         mem_r[wr_ptr_r] <= data_i;
      end
   end

   // FIFO pointers, occupancy and sticky overflow
   always_ff @(posedge sys_clk_i or negedge sys_rst_n_i) begin
      if (!sys_rst_n_i) begin
         wr_ptr_r   <= '0;
         rd_ptr_r   <= '0;
         level_r    <= '0;
         overflow_r <= 1'b0;
      end else begin
         if (push_s) begin
            wr_ptr_r <= wr_ptr_r + AW'(1);
         end
         if (pop_s) begin
            rd_ptr_r <= rd_ptr_r + AW'(1);
         end
         case ({push_s, pop_s})
            2'b10:   level_r <= level_r + (AW+1)'(1);
            2'b01:   level_r <= level_r - (AW+1)'(1);
            default: level_r <= level_r;
         endcase
         if (valid_i && full_s) begin
            overflow_r <= 1'b1;
         end
      end
   end

   // Tick prescaler and per-bit tick counter, realigned at every frame start
   always_ff @(posedge sys_clk_i or negedge sys_rst_n_i) begin
      if (!sys_rst_n_i) begin
         presc_r    <= 16'd0;
         tick_cnt_r <= 4'd0;
      end else if (pop_s) begin
         presc_r    <= 16'd0;
         tick_cnt_r <= 4'd0;
      end else if (state_r != IDLE) begin
         if (tick_s) begin
            presc_r    <= 16'd0;
            tick_cnt_r <= tick_cnt_r + 4'd1;
         end else begin
            presc_r <= presc_r + 16'd1;
         end
      end else begin
         presc_r    <= 16'd0;
         tick_cnt_r <= 4'd0;
      end
   end

   // Frame state, shifter and registered serial line
   always_ff @(posedge sys_clk_i or negedge sys_rst_n_i) begin
      if (!sys_rst_n_i) begin
         state_r   <= IDLE;
         shift_r   <= 8'd0;
         bit_cnt_r <= 3'd0;
         tx_r      <= 1'b1;
      end else begin
         state_r   <= state_n_s;
         shift_r   <= shift_n_s;
         bit_cnt_r <= bit_cnt_n_s;
         tx_r      <= tx_n_s;
      end
   end

   // Next-state logic; the line value is derived from the next state so it changes on the transition edge
   always_comb begin
      state_n_s   = state_r;
      shift_n_s   = shift_r;
      bit_cnt_n_s = bit_cnt_r;
      pop_s       = 1'b0;
      tx_n_s      = 1'b1;
      case (state_r)
         IDLE: begin
            if (level_r != '0) begin
               state_n_s = START;
               pop_s     = 1'b1;
               shift_n_s = mem_r[rd_ptr_r];
            end else begin
               state_n_s = IDLE;
            end
         end
         START: begin
            if (bit_done_s) begin
               state_n_s   = DATA;
               bit_cnt_n_s = 3'd0;
            end else begin
               state_n_s = START;
            end
         end
         DATA: begin
            if (bit_done_s) begin
               if (bit_cnt_r == 3'd7) begin
                  state_n_s = STOP;
               end else begin
                  shift_n_s   = {1'b0, shift_r[7:1]};
                  bit_cnt_n_s = bit_cnt_r + 3'd1;
               end
            end else begin
               state_n_s = DATA;
            end
         end
         STOP: begin
            if (bit_done_s) begin
               if (level_r != '0) begin
                  state_n_s = START;
                  pop_s     = 1'b1;
                  shift_n_s = mem_r[rd_ptr_r];
               end else begin
                  state_n_s = IDLE;
               end
            end else begin
               state_n_s = STOP;
            end
         end
         default: begin
            state_n_s = IDLE;
         end
      endcase
      case (state_n_s)
         START:   tx_n_s = 1'b0;
         DATA:    tx_n_s = shift_n_s[0];
         default: tx_n_s = 1'b1;
      endcase
   end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: directed writes feed an expected-byte queue that a
// line-decoding monitor pops as frames appear on uart_tx_o.
module tb_uart_tx_fifo;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [15:0] div;
   logic [7:0]  din;
   logic        valid;
   logic        ready;
   logic [3:0]  level;
   logic        busy;
   logic        ovf;
   logic        tx;

   uart_tx_fifo #(.DEPTH(8)) dut (
      .sys_clk_i   (clk),
      .sys_rst_n_i (rst_n),
      .divisor_i   (div),
      .data_i      (din),
      .valid_i     (valid),
      .ready_o     (ready),
      .level_o     (level),
      .busy_o      (busy),
      .overflow_o  (ovf),
      .uart_tx_o   (tx)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic [7:0] exp_q[$];
   int  B = 32;
   bit  mon_en = 1'b1;
   bit  gap_chk = 1'b0;
   int  rx_count = 0;

   function automatic void chk(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d", name, act, req);
      end
   endfunction

   // Line monitor: mid-bit sampling receiver acting as the scoreboard consumer
   int         rx_t;
   bit         rx_busy = 1'b0;
   logic [7:0] rx_sh;
   int         prev_start;
   bit         prev_valid = 1'b0;
   always @(negedge clk) begin
      if (!gap_chk) prev_valid = 1'b0;
      if (!rst_n || !mon_en) begin
         rx_busy = 1'b0;
      end else if (!rx_busy) begin
         if (tx == 1'b0) begin
            rx_busy = 1'b1;
            rx_t = 0;
            if (gap_chk && prev_valid) chk("frame_gap", cyc - prev_start, 10 * B);
            prev_start = cyc;
            prev_valid = 1'b1;
         end
      end else begin
         rx_t++;
         if (rx_t == B / 2) begin
            chk("start_bit", tx, 0);
         end else if ((rx_t % B == B / 2) && (rx_t / B >= 1) && (rx_t / B <= 8)) begin
            rx_sh[rx_t / B - 1] = tx;
         end else if (rx_t == 9 * B + B / 2) begin
            chk("stop_bit", tx, 1);
            rx_count++;
            if (exp_q.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL rx_unexpected actual=%0h required=none", rx_sh);
            end else begin
               chk("rx_byte", rx_sh, exp_q.pop_front());
            end
            rx_busy = 1'b0;
         end
      end
   end

   // Called at a negedge; drives one byte across the next rising edge
   task automatic write(input logic [7:0] b, input bit acc);
      din = b;
      valid = 1'b1;
      chk("ready_before_write", ready, acc);
      if (acc) exp_q.push_back(b);
      @(negedge clk);
      valid = 1'b0;
   endtask

   task automatic wait_idle(input int maxc);
      int n = 0;
      while (busy && n < maxc) begin
         @(negedge clk);
         n++;
      end
      chk("idle_within_bound", busy, 0);
   endtask

   int exp_line[10] = '{0, 1, 1, 0, 0, 0, 1, 0, 1, 1};
   int cn;
   int lows;
   int rx_base;

   initial begin
      rst_n = 1'b0;
      div = 16'd2;
      din = 8'd0;
      valid = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_tx", tx, 1);
      chk("rst_ready", ready, 1);
      chk("rst_level", level, 0);
      chk("rst_busy", busy, 0);
      chk("rst_overflow", ovf, 0);
      rst_n = 1'b1;
      @(negedge clk);

      // 0x55 at divisor 2: latency, 32-clock bits, busy drop at 320
      B = 32;
      write(8'h55, 1'b1);
      chk("lat_level_after_push", level, 1);
      chk("lat_tx_idle_after_push", tx, 1);
      @(negedge clk);
      chk("lat_tx_low_after_pop", tx, 0);
      chk("lat_level_after_pop", level, 0);
      for (int t = 1; t <= 320; t++) begin
         @(negedge clk);
         if (t == 31)  chk("start_low_31", tx, 0);
         if (t == 32)  chk("bit0_high_32", tx, 1);
         if (t == 319) chk("busy_319", busy, 1);
         if (t == 320) chk("busy_320", busy, 0);
      end

      // 0xA3 at divisor 0: 16-clock bits
      div = 16'd0;
      B = 16;
      write(8'hA3, 1'b1);
      @(negedge clk);
      for (int t = 1; t <= 160; t++) begin
         @(negedge clk);
         if (t % 16 == 8) chk("line_a3", tx, exp_line[t / 16]);
      end
      wait_idle(100);

      // Simultaneous push and pop at level 3
      write(8'h01, 1'b1);
      cn = cyc;
      write(8'h02, 1'b1);
      write(8'h03, 1'b1);
      write(8'h04, 1'b1);
      chk("level_three", level, 3);
      while (cyc < cn + 160) @(negedge clk);
      chk("level_before_pop", level, 3);
      write(8'h05, 1'b1);
      chk("level_push_pop", level, 3);
      wait_idle(1000);

      // Reset in the middle of a 0x00 frame with one byte queued
      write(8'h00, 1'b1);
      write(8'h11, 1'b1);
      repeat (60) @(negedge clk);
      chk("level_before_reset", level, 1);
      mon_en = 1'b0;
      rst_n = 1'b0;
      #1;
      chk("abort_tx", tx, 1);
      chk("abort_level", level, 0);
      chk("abort_busy", busy, 0);
      exp_q.delete();
      @(negedge clk);
      rst_n = 1'b1;
      lows = 0;
      repeat (200) begin
         @(negedge clk);
         if (tx == 1'b0) lows++;
      end
      chk("no_frames_after_reset", lows, 0);
      chk("busy_after_reset", busy, 0);
      mon_en = 1'b1;

      // Nine bytes fill shifter plus FIFO, tenth overflows; frames back-to-back
      div = 16'd26;
      B = 416;
      gap_chk = 1'b1;
      rx_base = rx_count;
      for (int i = 0; i < 9; i++) write(8'(8'h30 + i), 1'b1);
      chk("burst_level_full", level, 8);
      chk("burst_ready_low", ready, 0);
      chk("overflow_before_drop", ovf, 0);
      write(8'h39, 1'b0);
      chk("overflow_after_drop", ovf, 1);
      wait_idle(9 * 4160 + 200);
      chk("burst_frame_count", rx_count - rx_base, 9);
      gap_chk = 1'b0;

      // Reset clears overflow; acceptance on first edge after release; "Hi\n"
      rst_n = 1'b0;
      #1;
      chk("overflow_cleared", ovf, 0);
      @(negedge clk);
      rst_n = 1'b1;
      rx_base = rx_count;
      write(8'h48, 1'b1);
      chk("first_edge_accept", level, 1);
      write(8'h69, 1'b1);
      write(8'h0A, 1'b1);
      wait_idle(3 * 4160 + 200);
      chk("hi_frame_count", rx_count - rx_base, 3);
      chk("queue_drained", exp_q.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
